// File: rtl/gpio_bank_if.sv
// gpio_bank_if: CPU-side register bus of the GPIO bank.
//   addr  : word offset inside the GPIO window (decoded by the top level)
//   wdata : write data
//   we    : byte write enables; only a full-word write (all four set) acts
//   re    : read strobe
//   rdata : registered read data, valid the cycle after re
// master = CPU/bus side, slave = gpio_bank.
interface gpio_bank_if;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO peripheral with NUM_PINS channels.
// Each channel has output value / output enable registers, a synchronised
// (optionally debounced) input, rising/falling edge detection into a sticky
// write-1-to-clear STATUS register, and one combined interrupt line.
//
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   bus     : gpio_bank_if.slave register bus (addr/wdata/we/re/rdata)
//   pin_in  : raw asynchronous pad inputs
//   pin_out : output value per pin (OUT register)
//   pin_oe  : 1 = drive pin_out, 0 = high impedance (OE register)
//   irq     : OR of STATUS bits whose RISE_EN or FALL_EN is set
//
// Register map (word offset): 0 OUT, 1 OE, 2 IN (RO), 3 RISE_EN, 4 FALL_EN,
// 5 STATUS (W1C), 6 OUT_SET (WO), 7 OUT_CLR (WO).
//
// Build option: define GPIO_DEBOUNCE_EN to add a per-pin debounce filter of
// DEBOUNCE_CYCLES stable cycles between the synchroniser and IN/edge detect.
module gpio_bank #(
  parameter int NUM_PINS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  gpio_bank_if.slave          bus,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic                irq
);

`ifdef GPIO_DEBOUNCE_EN
  localparam int DB_EN = 1;
`else
  localparam int DB_EN = 0;
`endif
  // Edge detection stays blind until a pad level present during reset has
  // propagated all the way through to prev.
  localparam int WARM   = SYNC_STAGES + 1 + DB_EN * DEBOUNCE_CYCLES;
  localparam int WARM_W = $clog2(WARM + 1);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_OE   = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam logic [2:0] A_SET  = 3'd6;
  localparam logic [2:0] A_CLR  = 3'd7;

  typedef logic [NUM_PINS-1:0] pins_t;

  // Register bits above NUM_PINS-1 read as zero.
  function automatic logic [31:0] zext(input pins_t v);
    logic [31:0] r;
    r = '0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  pins_t              out_q, oe_q, rise_en_q, fall_en_q, status_q;
  pins_t              sync_p [SYNC_STAGES];
  pins_t              sync, filt, prev_q, rise, fall, w1c, wr_data;
  logic [WARM_W-1:0]  warm_cnt;
  logic               armed, wr_full;
  logic [31:0]        rd_mux, rdata_q;
  logic               unused_wdata;

  assign wr_full      = &bus.we;
  assign wr_data      = bus.wdata[NUM_PINS-1:0];
  assign unused_wdata = ^bus.wdata;

  // Stage: pad synchroniser (sync_p[0] is the metastability catcher)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end
  assign sync = sync_p[SYNC_STAGES-1];

  // Stage: input filter
`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] db_cnt [NUM_PINS];
  pins_t            filt_q;

  // The counter's next value reaching DEBOUNCE_CYCLES is the update edge,
  // so filt follows sync exactly DEBOUNCE_CYCLES cycles after sync moved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_PINS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (sync[i] == filt_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
  assign filt = filt_q;
`else
  assign filt = sync;
`endif

  // Stage: warm-up counter, saturates until the next reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       warm_cnt <= '0;
    else if (!armed) warm_cnt <= warm_cnt + WARM_W'(1);
  end
  assign armed = (warm_cnt == WARM_W'(WARM));

  assign rise = armed ? (filt & ~prev_q & rise_en_q) : '0;
  assign fall = armed ? (~filt & prev_q & fall_en_q) : '0;
  assign w1c  = (wr_full && bus.addr == A_STAT) ? wr_data : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      A_OUT:   rd_mux = zext(out_q);
      A_OE:    rd_mux = zext(oe_q);
      A_IN:    rd_mux = zext(filt);
      A_RISE:  rd_mux = zext(rise_en_q);
      A_FALL:  rd_mux = zext(fall_en_q);
      A_STAT:  rd_mux = zext(status_q);
      default: rd_mux = '0;
    endcase
  end

  // Stage: register file, edge status, read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      rdata_q   <= '0;
    end else begin
      if (wr_full) begin
        case (bus.addr)
          A_OUT:   out_q     <= wr_data;
          A_OE:    oe_q      <= wr_data;
          A_RISE:  rise_en_q <= wr_data;
          A_FALL:  fall_en_q <= wr_data;
          A_SET:   out_q     <= out_q | wr_data;
          A_CLR:   out_q     <= out_q & ~wr_data;
          default: ;
        endcase
      end
      // A new edge wins over a simultaneous write-1-to-clear of that bit.
      status_q <= (status_q & ~w1c) | rise | fall;
      prev_q   <= filt;
      if (bus.re) rdata_q <= rd_mux;
    end
  end

  assign bus.rdata = rdata_q;
  assign pin_out   = out_q;
  assign pin_oe    = oe_q;
  assign irq       = |(status_q & (rise_en_q | fall_en_q));

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: self-checking bench for gpio_bank (NUM_PINS=8, SYNC_STAGES=2).
module tb_gpio_bank;
  localparam int NP = 8;
  localparam int SS = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] pin_in, pin_out, pin_oe;
  logic          irq;

  gpio_bank_if bus ();

  gpio_bank #(.NUM_PINS(NP), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = w;
    @(posedge clk);
    #1;
    bus.we = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.re   = 1'b1;
    @(posedge clk);
    #1;
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  // Returns just after the negedge on which reset is released; the next
  // posedge is the first edge out of reset.
  task automatic do_reset(input logic [NP-1:0] pins);
    @(negedge clk);
    pin_in = pins;
    bus.we = 4'h0;
    bus.re = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model state for the randomized run
  logic [NP-1:0] m_out, m_oe, m_rise, m_fall, m_stat, m_prev, m_filt;
  logic [NP-1:0] m_wd, m_w1c, m_r, m_f;
  logic [31:0]   m_rd;
  logic [NP-1:0] dq [$];
  int            edge_n;

  initial begin
    logic [31:0] d;
    bus.addr = '0; bus.wdata = '0; bus.we = '0; bus.re = 1'b0;
    pin_in = '0; reset = 1'b1;

    vecs[0] = '{3'd1, 32'h0000000F, 4'hF, 3'd1, 32'h0000000F, 8'h00, 8'h0F};
    vecs[1] = '{3'd0, 32'h000000A5, 4'hF, 3'd0, 32'h000000A5, 8'hA5, 8'h0F};
    vecs[2] = '{3'd6, 32'h00000010, 4'hF, 3'd0, 32'h000000B5, 8'hB5, 8'h0F};
    vecs[3] = '{3'd7, 32'h00000001, 4'hF, 3'd0, 32'h000000B4, 8'hB4, 8'h0F};
    vecs[4] = '{3'd0, 32'h000000FF, 4'h1, 3'd0, 32'h000000B4, 8'hB4, 8'h0F};
    vecs[5] = '{3'd6, 32'hFFFFFFFF, 4'h7, 3'd0, 32'h000000B4, 8'hB4, 8'h0F};
    vecs[6] = '{3'd2, 32'h000000FF, 4'hF, 3'd6, 32'h00000000, 8'hB4, 8'h0F};
    vecs[7] = '{3'd0, 32'hFFFFFFB4, 4'hF, 3'd0, 32'h000000B4, 8'hB4, 8'h0F};
    vecs[8] = '{3'd7, 32'h00000000, 4'hF, 3'd7, 32'h00000000, 8'hB4, 8'h0F};

    // Reset values
    do_reset(8'h00);
    #1;
    check("rst_pin_oe", 32'(pin_oe), 32'h0);
    check("rst_pin_out", 32'(pin_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), d);
      check($sformatf("rst_read_%0d", a), d, 32'h0);
    end

    // Pins held high through reset must not produce a rising edge
    do_reset(8'hFF);
    bus_write(3'd3, 32'hFF, 4'hF);
    repeat (SS + DB + 10) @(posedge clk);
    bus_read(3'd5, d);
    check("warmup_status", d, 32'h0);
    check("warmup_irq", 32'(irq), 32'h0);
    bus_read(3'd2, d);
    check("warmup_in", d, 32'hFF);

    // Register file behaviour, table driven
    do_reset(8'h00);
    for (int i = 0; i < 9; i++) begin
      bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].we);
      check($sformatf("vec%0d_pin_out", i), 32'(pin_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_pin_oe", i), 32'(pin_oe), 32'(vecs[i].exp_oe));
      bus_read(vecs[i].raddr, d);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
    end

    // Rising edge latency, status and W1C
    bus_write(3'd3, 32'h01, 4'hF);
    @(negedge clk);
    pin_in[0] = 1'b1;
    repeat (1 + DB) @(posedge clk);
    bus_read(3'd2, d);
    check("in_latency_early", d, 32'h0);
    bus_read(3'd2, d);
    check("in_latency", d, 32'h1);
    bus_read(3'd5, d);
    check("rise_status", d, 32'h1);
    check("rise_irq", 32'(irq), 32'h1);
    bus_write(3'd5, 32'h01, 4'hF);
    bus_read(3'd5, d);
    check("w1c_status", d, 32'h0);
    check("w1c_irq", 32'(irq), 32'h0);

    // Falling edge captured on the same edge as a W1C of that bit
    @(negedge clk);
    pin_in[7] = 1'b1;
    repeat (SS + DB + 4) @(posedge clk);
    bus_write(3'd4, 32'h80, 4'hF);
    @(negedge clk);
    pin_in[7] = 1'b0;
    repeat (2 + DB) @(posedge clk);
    bus_write(3'd5, 32'h80, 4'hF);
    bus_read(3'd5, d);
    check("set_beats_clear", d, 32'h80);
    check("set_beats_clear_irq", 32'(irq), 32'h1);
    bus_write(3'd5, 32'h80, 4'hF);
    bus_read(3'd5, d);
    check("fall_cleared", d, 32'h0);

    // Disabling the enables masks irq but keeps STATUS
    bus_write(3'd3, 32'h04, 4'hF);
    @(negedge clk);
    pin_in[2] = 1'b1;
    repeat (SS + DB + 4) @(posedge clk);
    bus_read(3'd5, d);
    check("pend_status", d, 32'h04);
    check("pend_irq", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h0, 4'hF);
    bus_write(3'd4, 32'h0, 4'hF);
    check("masked_irq", 32'(irq), 32'h0);
    bus_read(3'd5, d);
    check("masked_status", d, 32'h04);
    bus_write(3'd3, 32'h04, 4'hF);
    check("reenabled_irq", 32'(irq), 32'h1);
    bus_write(3'd5, 32'hFFFFFFFB, 4'hF);
    bus_read(3'd5, d);
    check("w1c_other_bits", d, 32'h04);

    // Asynchronous reset in the middle of operation
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_oe", 32'(pin_oe), 32'h0);
    check("async_rst_out", 32'(pin_out), 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(3'd5, d);
    check("async_rst_status", d, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short glitch is swallowed, long pulse passes after 16 cycles
    do_reset(8'h00);
    repeat (DB + 10) @(posedge clk);
    bus_write(3'd3, 32'h02, 4'hF);
    @(negedge clk);
    pin_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    pin_in[1] = 1'b0;
    repeat (40) @(posedge clk);
    bus_read(3'd2, d);
    check("glitch_in", d & 32'h2, 32'h0);
    bus_read(3'd5, d);
    check("glitch_status", d, 32'h0);
    @(negedge clk);
    pin_in[1] = 1'b1;
    repeat (1 + DB) @(posedge clk);
    bus_read(3'd2, d);
    check("debounce_early", d & 32'h2, 32'h0);
    bus_read(3'd2, d);
    check("debounce_in", d & 32'h2, 32'h2);
    repeat (2) @(negedge clk);
    pin_in[1] = 1'b0;
    bus_read(3'd5, d);
    check("debounce_status", d, 32'h2);
`else
    // Randomized traffic against the reference model
    do_reset(8'h00);
    m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    m_prev = '0; m_filt = '0; m_rd = '0; edge_n = 0;
    dq.delete();
    for (int i = 0; i < SS - 1; i++) dq.push_back('0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < NP; b++)
        if ($urandom_range(7) == 0) pin_in[b] = ~pin_in[b];
      bus.re    = 1'($urandom_range(1));
      bus.addr  = 3'($urandom_range(7));
      bus.wdata = $urandom;
      case ($urandom_range(3))
        0, 1:    bus.we = 4'hF;
        2:       bus.we = 4'h0;
        default: bus.we = 4'($urandom_range(14));
      endcase
      @(posedge clk);
      edge_n++;
      // filt is the pad value sampled SS edges ago; edges are ignored for
      // the first SS+1 edges after reset.
      if (bus.re) begin
        case (bus.addr)
          3'd0:    m_rd = 32'(m_out);
          3'd1:    m_rd = 32'(m_oe);
          3'd2:    m_rd = 32'(m_filt);
          3'd3:    m_rd = 32'(m_rise);
          3'd4:    m_rd = 32'(m_fall);
          3'd5:    m_rd = 32'(m_stat);
          default: m_rd = 32'h0;
        endcase
      end
      m_wd = bus.wdata[NP-1:0];
      m_r  = (edge_n > SS + 1) ? (m_filt & ~m_prev & m_rise) : '0;
      m_f  = (edge_n > SS + 1) ? (~m_filt & m_prev & m_fall) : '0;
      m_w1c = (bus.we == 4'hF && bus.addr == 3'd5) ? m_wd : '0;
      m_stat = (m_stat & ~m_w1c) | m_r | m_f;
      if (bus.we == 4'hF) begin
        case (bus.addr)
          3'd0:    m_out = m_wd;
          3'd1:    m_oe = m_wd;
          3'd3:    m_rise = m_wd;
          3'd4:    m_fall = m_wd;
          3'd6:    m_out = m_out | m_wd;
          3'd7:    m_out = m_out & ~m_wd;
          default: ;
        endcase
      end
      m_prev = m_filt;
      dq.push_back(pin_in);
      m_filt = dq.pop_front();
      #1;
      check($sformatf("rnd%0d_pin_out", cyc), 32'(pin_out), 32'(m_out));
      check($sformatf("rnd%0d_pin_oe", cyc), 32'(pin_oe), 32'(m_oe));
      check($sformatf("rnd%0d_irq", cyc), 32'(irq), 32'(|(m_stat & (m_rise | m_fall))));
      check($sformatf("rnd%0d_rdata", cyc), bus.rdata, m_rd);
      @(negedge clk);
    end
    bus.we = 4'h0;
    bus.re = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Memory-mapped, parametrised GPIO peripheral with NUM_PINS independent channels. Each channel has:
- a per-pin output-enable (tri-state control) and output value;
- a synchronised input;
- rising/falling edge detection with sticky write-1-to-clear status and one combined interrupt line.

It sits on the CPU data bus next to RAM and the UART. It has one-cycle registered read data, like RAM. The top level builds the actual pad tri-state from pin_out/pin_oe.

Parameters:
NUM_PINS, 8, number of GPIO channels (1..32); register bits above NUM_PINS-1 read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser depth (>=2)
DEBOUNCE_CYCLES, 16, stable-input cycles required before filtered input changes (used only with GPIO_DEBOUNCE_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
addr  input  3  word offset within the GPIO window (decoded by top)
wdata  input  32  write data
we  input  4  byte write enables; a write takes effect only when all four are set
re  input  1  read strobe
rdata  output  32  read data, valid the cycle after re
pin_in  input  NUM_PINS  raw asynchronous pad inputs
pin_out  output  NUM_PINS  output value per pin
pin_oe  output  NUM_PINS  1 = drive pin_out, 0 = high impedance
irq  output  1  OR of (EDGE_STATUS & (RISE_EN | FALL_EN))

Behaviour:
- Reset (async, active-high). All of the following clear to 0: OUT, OE, RISE_EN, FALL_EN, STATUS, synchroniser and filter registers, prev-sample register, rdata, irq. All pins are hi-Z after reset.
- Register map (word offset, access):
  - 0 OUT (RW)
  - 1 OE (RW)
  - 2 IN (RO, filtered synced input)
  - 3 RISE_EN (RW)
  - 4 FALL_EN (RW)
  - 5 STATUS (RW1C)
  - 6 OUT_SET (WO: OUT |= wdata; reads 0)
  - 7 OUT_CLR (WO: OUT &= ~wdata; reads 0)
- Writes apply at the clock edge where &we=1. Partial-byte writes are ignored. Writes to IN are ignored.
- Reads: when re=1, rdata registers the addressed value on that edge and is valid on the next cycle. When re=0, rdata holds its last value.
- pin_out = OUT and pin_oe = OE, both direct from registers. They change the cycle after the write edge.
- Input path: pin_in passes through SYNC_STAGES flops, giving sync. The filter stage (pass-through without debounce) gives filt. IN reflects filt.
  - Latency from a pad change to IN updating is SYNC_STAGES cycles without debounce.
- Edge detect: prev <= filt every cycle.
  - rise = filt & ~prev & RISE_EN; fall = ~filt & prev & FALL_EN.
  - STATUS <= (STATUS & ~w1c) | rise | fall, where w1c = wdata on a full write to offset 5, else 0.
  - Set has priority over clear for the same bit in the same cycle.
- Warm-up: a counter of SYNC_STAGES+1 cycles after reset deassertion suppresses rise/fall. A pin held high through reset therefore does not produce a spurious rising edge. The counter saturates and never re-arms until the next reset.
- Clearing RISE_EN/FALL_EN does not clear pending STATUS bits, but irq masks them. irq is combinational from registers.
- Reset asserted mid-operation immediately clears all state, including pending STATUS, and forces pins hi-Z.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: each pin has a counter of width clog2(DEBOUNCE_CYCLES+1).
  - When sync != filt the counter increments; when they are equal it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES, filt takes the sync value and the counter resets.
  - Glitches shorter than DEBOUNCE_CYCLES never reach IN or edge detect.
  - Warm-up extends to SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
- Not defined: filt = sync, no counters are instantiated, and DEBOUNCE_CYCLES is unused.

Test Plan:
1. Reset, then read offsets 0..5 -> all read 0x00000000, pin_oe=0x00, irq=0; pin_in held 0xFF through reset -> STATUS stays 0 after warm-up with RISE_EN=0xFF.
2. Write OE=0x0F, OUT=0xA5, then OUT_SET=0x10, OUT_CLR=0x01 -> pin_oe=0x0F, pin_out=0xB4, OUT reads 0x000000B4; a partial write (we=4'b0001) of 0xFF to OUT leaves 0xB4.
3. RISE_EN=0x01, pin_in[0] 0->1 -> IN bit0 set after 2 cycles, STATUS=0x01, irq=1; write STATUS=0x01 -> STATUS=0, irq=0.
4. FALL_EN=0x80, pin_in[7] falls in the same cycle as a W1C write of 0x80 to STATUS -> STATUS bit7 remains 1.
5. Pending STATUS=0x04, then write RISE_EN=0 and FALL_EN=0 -> irq=0, STATUS still reads 0x04; re-enable RISE_EN=0x04 -> irq=1.
6. With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle pulse on pin_in[1] -> IN unchanged, no STATUS; a pulse held 20 cycles -> IN bit1 rises 16 cycles after the synchronised edge.
